// File: rtl/mem_port_arb.sv
// mem_port_arb: two-requester round-robin arbiter for a single shared memory port.
// Port0 is a read-only fetch port and port1 is a read/write data port.
// Each grant produces a fixed-length access of LAT cycles, followed by one idle cycle.
module mem_port_arb #(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [15:0] addr0,
  input  logic        req1,
  input  logic [15:0] addr1,
  input  logic        wr1,
  output logic        sel,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic        done0,
  output logic        done1,
  output logic        busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Index of the final BUSY cycle; LAT is limited to 1..15, so it fits the 4-bit counter.
  localparam logic [3:0] LAST_CNT = 4'(LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       last;       // most recently granted port: 0 = port0, 1 = port1
  logic       wr_q;       // write flag latched at grant
  logic       grant;
  logic       grant_p1;   // 1 when the grant goes to port1
  logic       final_cyc;

  assign final_cyc = (cnt == LAST_CNT);

  // State register; reset forces IDLE immediately, which aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and arbitration: a lone request wins, and a tie goes to the port not granted last.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_p1  = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant     = 1'b1;
          state_nxt = BUSY;
          if (req0 && req1) begin
            grant_p1 = ~last;
          end else begin
            grant_p1 = req1;
          end
        end
      end
      BUSY: begin
        if (final_cyc) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Access context and cycle counter; the context is captured at grant and frozen until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 4'd0;
      last     <= 1'b0;
      sel      <= 1'b0;
      mem_addr <= 16'd0;
      wr_q     <= 1'b0;
    end else if (grant) begin
      cnt      <= 4'd0;
      last     <= grant_p1;
      sel      <= ~grant_p1;
      mem_addr <= grant_p1 ? addr1 : addr0;
      wr_q     <= grant_p1 & wr1;
    end else if (state == BUSY) begin
      cnt <= final_cyc ? 4'd0 : cnt + 4'd1;
    end
  end

  // Status outputs are decoded from the state, so an asynchronous reset clears them at once.
  assign busy   = (state == BUSY);
  assign mem_en = busy;
  assign mem_wr = busy & wr_q;
  assign done0  = busy & final_cyc & sel;
  assign done1  = busy & final_cyc & ~sel;

endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: drives two arbiter instances (LAT=4 and LAT=1) with directed and
// randomized requester traffic, and compares every output every cycle against a
// transaction-level model of the arbitration rules.
module tb_mem_port_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0     [2];
  logic [15:0] a0     [2];
  logic        r1     [2];
  logic [15:0] a1     [2];
  logic        w1     [2];
  logic        sel_o  [2];
  logic        en_o   [2];
  logic        wr_o   [2];
  logic [15:0] addr_o [2];
  logic        d0_o   [2];
  logic        d1_o   [2];
  logic        busy_o [2];

  always #5 clk = ~clk;

  mem_port_arb #(.LAT(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0(r0[0]), .addr0(a0[0]), .req1(r1[0]), .addr1(a1[0]), .wr1(w1[0]),
    .sel(sel_o[0]), .mem_en(en_o[0]), .mem_wr(wr_o[0]), .mem_addr(addr_o[0]),
    .done0(d0_o[0]), .done1(d1_o[0]), .busy(busy_o[0])
  );

  mem_port_arb #(.LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .req0(r0[1]), .addr0(a0[1]), .req1(r1[1]), .addr1(a1[1]), .wr1(w1[1]),
    .sel(sel_o[1]), .mem_en(en_o[1]), .mem_wr(wr_o[1]), .mem_addr(addr_o[1]),
    .done0(d0_o[1]), .done1(d1_o[1]), .busy(busy_o[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: one record per instance describing the access in progress.
  int          lat      [2] = '{4, 1};
  bit          m_busy   [2];
  int          m_left   [2];   // BUSY cycles remaining, including the current one
  int          m_port   [2];   // port being served
  int          m_lastp  [2];   // port granted most recently
  bit          m_sel    [2];
  logic [15:0] m_addr   [2];
  bit          m_wr     [2];

  function automatic void model_reset(int d);
    m_busy[d]  = 1'b0;
    m_left[d]  = 0;
    m_port[d]  = 0;
    m_lastp[d] = 0;
    m_sel[d]   = 1'b0;
    m_addr[d]  = 16'h0000;
    m_wr[d]    = 1'b0;
  endfunction

  // Advance one clock edge using the inputs present at that edge.
  function automatic void model_step(int d);
    int gp;
    if (rst) begin
      model_reset(d);
      return;
    end
    if (m_busy[d]) begin
      m_left[d]--;
      if (m_left[d] == 0) m_busy[d] = 1'b0;
    end else if (r0[d] || r1[d]) begin
      if (r0[d] && r1[d]) gp = 1 - m_lastp[d];
      else                gp = r1[d] ? 1 : 0;
      m_port[d]  = gp;
      m_lastp[d] = gp;
      m_sel[d]   = (gp == 0);
      m_addr[d]  = (gp == 1) ? a1[d] : a0[d];
      m_wr[d]    = (gp == 1) ? w1[d] : 1'b0;
      m_left[d]  = lat[d];
      m_busy[d]  = 1'b1;
    end
  endfunction

  function automatic bit exp_done(int d, int p);
    return m_busy[d] && (m_left[d] == 1) && (m_port[d] == p);
  endfunction

  task automatic compare(input int d);
    chk($sformatf("L%0d.busy", lat[d]),     busy_o[d], m_busy[d]);
    chk($sformatf("L%0d.mem_en", lat[d]),   en_o[d],   m_busy[d]);
    chk($sformatf("L%0d.mem_wr", lat[d]),   wr_o[d],   m_busy[d] && m_wr[d]);
    chk($sformatf("L%0d.sel", lat[d]),      sel_o[d],  m_sel[d]);
    chk($sformatf("L%0d.mem_addr", lat[d]), addr_o[d], m_addr[d]);
    chk($sformatf("L%0d.done0", lat[d]),    d0_o[d],   exp_done(d, 0));
    chk($sformatf("L%0d.done1", lat[d]),    d1_o[d],   exp_done(d, 1));
  endtask

  // Requester behaviour and grant bookkeeping
  int  rate     = 0;
  bit  scramble = 1'b0;
  bit  keep_hi  [2] = '{1'b0, 1'b0};
  bit  prev_en  [2] = '{1'b0, 1'b0};
  int  en_cnt   [2] = '{0, 0};
  int  cyc      = 0;
  int  gc0 [$];
  int  gs0 [$];
  int  gc1 [$];

  task automatic auto_drive();
    for (int d = 0; d < 2; d++) begin
      if (exp_done(d, 0) && !keep_hi[d]) begin
        r0[d] = 1'b0;
      end else if (!r0[d] && rate > 0 && $urandom_range(99) < rate) begin
        r0[d] = 1'b1;
        a0[d] = 16'($urandom);
      end
      if (exp_done(d, 1) && !keep_hi[d]) begin
        r1[d] = 1'b0;
      end else if (!r1[d] && rate > 0 && $urandom_range(99) < rate) begin
        r1[d] = 1'b1;
        a1[d] = 16'($urandom);
        w1[d] = 1'($urandom);
      end
      if (scramble && m_busy[d]) begin
        a0[d] = 16'($urandom);
        a1[d] = 16'($urandom);
        w1[d] = 1'($urandom);
      end
    end
  endtask

  task automatic tick();
    for (int d = 0; d < 2; d++) model_step(d);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      compare(d);
      if (en_o[d] === 1'b1 && !prev_en[d]) begin
        if (d == 0) begin
          gc0.push_back(cyc);
          gs0.push_back(int'(sel_o[0]));
        end else begin
          gc1.push_back(cyc);
        end
      end
      prev_en[d] = (en_o[d] === 1'b1);
      if (en_o[d] === 1'b1) en_cnt[d]++;
    end
    auto_drive();
  endtask

  task automatic clear_log();
    gc0.delete();
    gs0.delete();
    gc1.delete();
    en_cnt[0] = 0;
    en_cnt[1] = 0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      r0[d] = 1'b0; a0[d] = 16'h0; r1[d] = 1'b0; a1[d] = 16'h0; w1[d] = 1'b0;
      model_reset(d);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single port0 access on LAT=4; continuous port0 requests on LAT=1
    clear_log();
    r0[0] = 1'b1; a0[0] = 16'h0040;
    keep_hi[1] = 1'b1; r0[1] = 1'b1; a0[1] = 16'h0100;
    repeat (6) tick();
    chk("single.en_cycles", en_cnt[0], 4);
    chk("single.grants", gc0.size(), 1);
    chk("single.sel", gs0.size() > 0 ? gs0[0] : -1, 1);
    chk("lat1.grants", gc1.size(), 3);
    chk("lat1.period", gc1.size() > 1 ? gc1[1] - gc1[0] : -1, 2);
    chk("lat1.en_cycles", en_cnt[1], 3);
    keep_hi[1] = 1'b0; r0[1] = 1'b0;
    tick();

    // Simultaneous requests right after reset: port1 (write) first, port0 five cycles later
    reset_pulse();
    clear_log();
    r0[0] = 1'b1; a0[0] = 16'h0ABC;
    r1[0] = 1'b1; a1[0] = 16'h1234; w1[0] = 1'b1;
    repeat (12) tick();
    chk("tie.grants", gc0.size(), 2);
    chk("tie.first_sel", gs0.size() > 0 ? gs0[0] : -1, 0);
    chk("tie.second_sel", gs0.size() > 1 ? gs0[1] : -1, 1);
    chk("tie.gap", gc0.size() > 1 ? gc0[1] - gc0[0] : -1, 5);
    w1[0] = 1'b0;

    // Both requests held continuously: grants alternate 1,0,1,0
    reset_pulse();
    clear_log();
    keep_hi[0] = 1'b1;
    r0[0] = 1'b1; a0[0] = 16'h0200;
    r1[0] = 1'b1; a1[0] = 16'h0300; w1[0] = 1'b0;
    repeat (20) tick();
    chk("rr.grants", gc0.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr.sel%0d", i), gs0.size() > i ? gs0[i] : -1, (i % 2 == 0) ? 0 : 1);
    end
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("rr.gap%0d", i), gc0.size() > i ? gc0[i] - gc0[i-1] : -1, 5);
    end
    keep_hi[0] = 1'b0; r0[0] = 1'b0; r1[0] = 1'b0;
    repeat (2) tick();

    // addr1/wr1 changed mid-access are ignored until the next grant
    r1[0] = 1'b1; a1[0] = 16'h5555; w1[0] = 1'b1;
    tick();
    tick();
    a1[0] = 16'hAAAA; w1[0] = 1'b0;
    tick();
    chk("hold.addr", addr_o[0], 16'h5555);
    chk("hold.wr", wr_o[0], 1'b1);
    tick();
    tick();
    r1[0] = 1'b1;
    tick();
    chk("regrant.addr", addr_o[0], 16'hAAAA);
    chk("regrant.wr", wr_o[0], 1'b0);
    repeat (5) tick();

    // Asynchronous reset during the second BUSY cycle
    r0[0] = 1'b1; a0[0] = 16'h0ABC;
    tick();
    tick();
    r1[0] = 1'b1; a1[0] = 16'h0777; w1[0] = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst.busy", busy_o[0], 1'b0);
    chk("arst.mem_en", en_o[0], 1'b0);
    chk("arst.mem_wr", wr_o[0], 1'b0);
    chk("arst.sel", sel_o[0], 1'b0);
    chk("arst.mem_addr", addr_o[0], 16'h0000);
    chk("arst.done0", d0_o[0], 1'b0);
    chk("arst.done1", d1_o[0], 1'b0);
    model_reset(0);
    model_reset(1);
    tick();
    rst = 1'b0;
    clear_log();
    tick();
    chk("arst.regrant", gc0.size(), 1);
    chk("arst.regrant_sel", gs0.size() > 0 ? gs0[0] : -1, 0);
    repeat (12) tick();

    // Randomized traffic on both instances, with address/write churn during accesses
    rate = 25;
    scramble = 1'b1;
    repeat (600) tick();
    rate = 0;
    scramble = 1'b0;
    for (int d = 0; d < 2; d++) begin
      r0[d] = 1'b0;
      r1[d] = 1'b0;
    end
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 Parameter: LAT, default 4, memory access length in cycles; legal range 1..15.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: req0  input  1  fetch-side request; level, held until done0.
REQ-005 Port: addr0  input  16  fetch address; read-only port.
REQ-006 Port: req1  input  1  data-side request; level, held until done1.
REQ-007 Port: addr1  input  16  data address.
REQ-008 Port: wr1  input  1  data-side write (1) / read (0).
REQ-009 Port: sel  output  1  shared-port select: 1 routes port0 (addr0 path), 0 routes port1.
REQ-010 Port: mem_en  output  1  memory enable, high for every cycle of an access.
REQ-011 Port: mem_wr  output  1  memory write strobe.
REQ-012 Port: mem_addr  output  16  registered address of the current access.
REQ-013 Port: done0  output  1  one-cycle pulse marking completion of a port0 access.
REQ-014 Port: done1  output  1  one-cycle pulse marking completion of a port1 access.
REQ-015 Port: busy  output  1  high while an access is in progress.

Function
REQ-016 FSM has two states: IDLE and BUSY; a 4-bit counter cnt counts BUSY cycles; a 1-bit register last records the most recently granted port.
REQ-017 In IDLE with no request, the block stays in IDLE and all outputs except sel and mem_addr are 0.
REQ-018 In IDLE with exactly one request, that port is granted at the next edge.
REQ-019 In IDLE with both requests, the port not equal to last is granted (round-robin).
REQ-020 At the grant edge, the block: loads mem_addr from the granted port's address; sets sel (1 for port0, 0 for port1); latches mem_wr = wr1 if port1 is granted, else 0; updates last; clears cnt; enters BUSY.
REQ-021 BUSY lasts exactly LAT cycles; mem_en and busy are 1 in each of those cycles.
REQ-022 mem_addr, sel and mem_wr are held constant throughout BUSY; input changes during BUSY are ignored.
REQ-023 The done pulse for the granted port is 1 in the final BUSY cycle (cnt == LAT-1) only; done0 and done1 are never high together.
REQ-024 The edge after the final BUSY cycle returns the FSM to IDLE; a grant occurs no earlier than that IDLE cycle.
REQ-025 Consecutive accesses are therefore separated by exactly one IDLE cycle.
REQ-026 A requester deasserts its req on the edge ending its done cycle; a req still high in the following IDLE cycle is a new request.
REQ-027 A request arriving in BUSY waits; it is arbitrated in the next IDLE cycle under REQ-018 and REQ-019.
REQ-028 With LAT = 1, BUSY is a single cycle carrying both mem_en and done.
REQ-029 In IDLE, sel and mem_addr retain their last granted values.

Reset
REQ-030 While rst = 1, the state is forced to IDLE immediately, without waiting for a clock edge.
REQ-031 During reset: cnt = 0; last = 0 (port1 wins the first tie); sel = 0; mem_addr = 0; mem_en = mem_wr = busy = done0 = done1 = 0.
REQ-032 Reset during BUSY aborts the access with no done pulse; the first grant may occur in the first IDLE cycle after rst falls.

Verification
REQ-033 Bench shall cover, LAT=4: req0=1, addr0=0x0040, held -> grant edge, then mem_en=1/sel=1/mem_addr=0x0040 for 4 cycles, done0 in 4th cycle only, then 1 IDLE cycle.
REQ-034 Bench shall cover, after reset, req0=req1=1 same cycle, wr1=1, addr1=0x1234 -> port1 served first with mem_wr=1 and sel=0; port0 served second, starting 5 cycles after port1's grant.
REQ-035 Bench shall cover both requests held continuously for 4 accesses -> grants alternate 1,0,1,0; each done pulse is 1 cycle; each pair of accesses is separated by one idle cycle.
REQ-036 Bench shall cover addr1/wr1 changed mid-BUSY -> mem_addr and mem_wr unchanged until the next grant.
REQ-037 Bench shall cover rst asserted asynchronously in the 2nd BUSY cycle -> outputs zero before the next edge; no done pulse; a pending req is granted after rst falls.
REQ-038 Bench shall cover LAT=1 with req0 held -> mem_en and done0 high in the same single cycle; accesses recur every 2 cycles.
